pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges stage holds, jump redirect and interrupt hold into stall/flush vectors.
// Latency: stall/flush/redirect outputs are combinational (zero cycles); counters and watchdog update on the next edge.
// Backpressure: a stage asserting hold stalls itself and everything upstream; jump/irq/flush windows override holds.
module pipe_hazard_ctrl #(
   parameter int ADDR_W     = 64,
   parameter int N_STAGES   = 5,
   parameter int JUMP_STAGE = 2,
   parameter int FLUSH_LEN  = 1,
   parameter int STALL_MAX  = 255,
   parameter int CNT_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   jump_addr_i,
   input  logic                jump_en_i,
   input  logic                irq_hold_i,
   input  logic [N_STAGES-1:0] hold_req_i,
   output logic [ADDR_W-1:0]   jump_addr_o,
   output logic                jump_en_o,
   output logic [N_STAGES-1:0] stall_o,
   output logic [N_STAGES-1:0] flush_o,
   output logic                stall_timeout_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   localparam int FC_W = $clog2(FLUSH_LEN + 1);
   localparam int WD_W = $clog2(STALL_MAX + 1);

   logic [FC_W-1:0] r_flush_cnt;
   logic [WD_W-1:0] r_wd_cnt;
   logic            w_hold_any;
   int              w_hold_idx;
   logic            w_rule4;

   // Redirect passes straight through to fetch, masked while in reset
   assign jump_en_o   = jump_en_i & ~rst;
   assign jump_addr_o = jump_en_o ? jump_addr_i : '0;

   // Find the most downstream stage currently requesting a hold
   always_comb begin
      w_hold_any = |hold_req_i;
      w_hold_idx = 0;
      for (int k = 0; k < N_STAGES; k++) begin
         if (hold_req_i[k]) w_hold_idx = k;
      end
   end

   // Priority resolution: reset, jump, irq hold, post-jump window, stage hold, idle
   always_comb begin
      stall_o = '0;
      flush_o = '0;
      w_rule4 = 1'b0;
      if (rst) begin
         flush_o = '1;
      end else if (jump_en_i || irq_hold_i) begin
         for (int k = 0; k < N_STAGES; k++) begin
            if (k <= JUMP_STAGE) flush_o[k] = 1'b1;
         end
      end else if (r_flush_cnt != '0) begin
         // Jumping stage itself already advanced; only the younger stages are wrong-path
         for (int k = 0; k < N_STAGES; k++) begin
            if (k < JUMP_STAGE) flush_o[k] = 1'b1;
         end
      end else if (w_hold_any) begin
         w_rule4 = 1'b1;
         for (int k = 0; k < N_STAGES; k++) begin
            stall_o[k] = (k <= w_hold_idx);
            // Stage just below the stalled region receives a bubble
            flush_o[k] = (k == w_hold_idx + 1);
         end
      end
   end

   // Post-jump flush window: a new jump restarts it, otherwise it counts down
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_cnt <= '0;
      end else if (jump_en_i) begin
         r_flush_cnt <= FC_W'(FLUSH_LEN - 1);
      end else if (r_flush_cnt != '0) begin
         r_flush_cnt <= r_flush_cnt - 1'b1;
      end
   end

   // Watchdog counts consecutive stall cycles, saturating, cleared by any non-stall cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt <= '0;
      end else if (w_rule4) begin
         if (r_wd_cnt != WD_W'(STALL_MAX)) r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
         r_wd_cnt <= '0;
      end
   end

   // Sticky timeout flag raised on the stall cycle that completes STALL_MAX in a row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_timeout_o <= 1'b0;
      end else if (w_rule4 && (r_wd_cnt == WD_W'(STALL_MAX - 1))) begin
         stall_timeout_o <= 1'b1;
      end
   end

   // Saturating total of stall cycles for performance monitoring
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (w_rule4 && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with FLUSH_LEN=3, STALL_MAX=4, narrow stall counter.
// Vectors carry inputs and expected outputs; counter/timeout expectations are the values visible before that cycle's edge.
// Hand sequences cover counter saturation and asynchronous reset in the middle of a cycle.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic        rst;
      logic        jen;
      logic [63:0] jaddr;
      logic        irq;
      logic [4:0]  hold;
      logic        ejen;
      logic [63:0] eaddr;
      logic [4:0]  estall;
      logic [4:0]  eflush;
      logic [3:0]  ecnt;
      logic        eto;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] jump_addr_i = '0;
   logic        jump_en_i = 1'b0;
   logic        irq_hold_i = 1'b0;
   logic [4:0]  hold_req_i = '0;
   logic [63:0] jump_addr_o;
   logic        jump_en_o;
   logic [4:0]  stall_o;
   logic [4:0]  flush_o;
   logic        stall_timeout_o;
   logic [3:0]  stall_cnt_o;

   int checks = 0;
   int failures = 0;
   vec_t tbl[$];
   vec_t sb[$];

   pipe_hazard_ctrl #(
      .ADDR_W(64), .N_STAGES(5), .JUMP_STAGE(2),
      .FLUSH_LEN(3), .STALL_MAX(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .jump_addr_i(jump_addr_i), .jump_en_i(jump_en_i),
      .irq_hold_i(irq_hold_i), .hold_req_i(hold_req_i),
      .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o),
      .stall_o(stall_o), .flush_o(flush_o),
      .stall_timeout_o(stall_timeout_o), .stall_cnt_o(stall_cnt_o)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic j, input logic [63:0] a, input logic i,
                      input logic [4:0] h, input logic ej, input logic [63:0] ea,
                      input logic [4:0] es, input logic [4:0] ef, input logic [3:0] ec,
                      input logic et);
      vec_t v;
      v.rst = r; v.jen = j; v.jaddr = a; v.irq = i; v.hold = h;
      v.ejen = ej; v.eaddr = ea; v.estall = es; v.eflush = ef; v.ecnt = ec; v.eto = et;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t e;
      // reset: flush-all, redirect masked even with a jump present
      add(1, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b11111, 0, 0);
      add(1, 1, 64'h8000_0040,  0, 5'b00000, 0, 64'h0,          5'b00000, 5'b11111, 0, 0);
      add(1, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b11111, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 0, 0);
      // hold from stage 2 for 4 cycles
      add(0, 0, 64'h0,          0, 5'b00100, 0, 64'h0,          5'b00111, 5'b01000, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00100, 0, 64'h0,          5'b00111, 5'b01000, 1, 0);
      add(0, 0, 64'h0,          0, 5'b00100, 0, 64'h0,          5'b00111, 5'b01000, 2, 0);
      add(0, 0, 64'h0,          0, 5'b00100, 0, 64'h0,          5'b00111, 5'b01000, 3, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 4, 1);
      // reset raised mid-cycle clears counters without an edge
      add(1, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b11111, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 0, 0);
      // single jump and its 3-cycle window
      add(0, 1, 64'h8000_0040,  0, 5'b00000, 1, 64'h8000_0040,  5'b00000, 5'b00111, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00011, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00011, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 0, 0);
      // second jump restarts window; hold from last stage ignored until window ends
      add(0, 1, 64'h0000_1000,  0, 5'b10000, 1, 64'h0000_1000,  5'b00000, 5'b00111, 0, 0);
      add(0, 1, 64'h0000_2000,  0, 5'b10000, 1, 64'h0000_2000,  5'b00000, 5'b00111, 0, 0);
      add(0, 0, 64'h0,          0, 5'b10000, 0, 64'h0,          5'b00000, 5'b00011, 0, 0);
      add(0, 0, 64'h0,          0, 5'b10000, 0, 64'h0,          5'b00000, 5'b00011, 0, 0);
      add(0, 0, 64'h0,          0, 5'b10000, 0, 64'h0,          5'b11111, 5'b00000, 0, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 1, 0);
      // irq hold beats a stage hold and does not count as a stall
      add(0, 0, 64'h0,          1, 5'b00010, 0, 64'h0,          5'b00000, 5'b00111, 1, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 1, 0);
      // irq inside a window still lets the window count down
      add(0, 1, 64'h0000_0300,  0, 5'b00000, 1, 64'h0000_0300,  5'b00000, 5'b00111, 1, 0);
      add(0, 0, 64'h0,          1, 5'b00000, 0, 64'h0,          5'b00000, 5'b00111, 1, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00011, 1, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 1, 0);
      // watchdog: 4 consecutive stalls from stage 0
      add(0, 0, 64'h0,          0, 5'b00001, 0, 64'h0,          5'b00001, 5'b00010, 1, 0);
      add(0, 0, 64'h0,          0, 5'b00001, 0, 64'h0,          5'b00001, 5'b00010, 2, 0);
      add(0, 0, 64'h0,          0, 5'b00001, 0, 64'h0,          5'b00001, 5'b00010, 3, 0);
      add(0, 0, 64'h0,          0, 5'b00001, 0, 64'h0,          5'b00001, 5'b00010, 4, 0);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 5, 1);
      add(0, 0, 64'h0,          0, 5'b00000, 0, 64'h0,          5'b00000, 5'b00000, 5, 1);

      @(posedge clk); #1;
      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; jump_en_i = tbl[i].jen; jump_addr_i = tbl[i].jaddr;
         irq_hold_i = tbl[i].irq; hold_req_i = tbl[i].hold;
         sb.push_back(tbl[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("v%0d jump_en", i), 64'(jump_en_o), 64'(e.ejen));
         chk($sformatf("v%0d jump_addr", i), jump_addr_o, e.eaddr);
         chk($sformatf("v%0d stall", i), 64'(stall_o), 64'(e.estall));
         chk($sformatf("v%0d flush", i), 64'(flush_o), 64'(e.eflush));
         chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt_o), 64'(e.ecnt));
         chk($sformatf("v%0d timeout", i), 64'(stall_timeout_o), 64'(e.eto));
         @(posedge clk); #1;
      end

      // saturation: 12 more stall cycles from 5 must stop at 15, not wrap
      hold_req_i = 5'b01010;
      @(negedge clk);
      chk("sat stall", 64'(stall_o), 64'(5'b01111));
      chk("sat flush", 64'(flush_o), 64'(5'b10000));
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      hold_req_i = 5'b00000;
      @(negedge clk);
      chk("sat cnt", 64'(stall_cnt_o), 64'd15);
      chk("sat timeout sticky", 64'(stall_timeout_o), 64'd1);

      // reset pulse inside a flush window kills the window immediately
      @(posedge clk); #1;
      jump_en_i = 1'b1; jump_addr_i = 64'h40;
      @(negedge clk);
      chk("win jump flush", 64'(flush_o), 64'(5'b00111));
      @(posedge clk); #1;
      jump_en_i = 1'b0; jump_addr_i = '0;
      #2 rst = 1'b1;
      #1;
      chk("async rst flush", 64'(flush_o), 64'(5'b11111));
      chk("async rst timeout", 64'(stall_timeout_o), 64'd0);
      chk("async rst cnt", 64'(stall_cnt_o), 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("window killed", 64'(flush_o), 64'(5'b00000));
      chk("post rst stall", 64'(stall_o), 64'(5'b00000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
